// File: rtl/mult_pkg.sv
// Shared constants for the pipelined multiplier.
// Default operand width and product-width helper.
package mult_pkg;
  localparam int WIDTH_DEF = 8;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/pipelined_multiplier_if.sv
// Operand/result bundle for the pipelined multiplier.
// master drives operands; slave returns the product.
interface pipelined_multiplier_if
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  localparam int PW = prod_w(WIDTH);

  logic [WIDTH-1:0] INPUT_A;
  logic [WIDTH-1:0] INPUT_B;
  logic             IN_VALID;
  logic [PW-1:0]    RES;
  logic             OUT_VALID;

  modport master (
    output INPUT_A,
    output INPUT_B,
    output IN_VALID,
    input  RES,
    input  OUT_VALID
  );

  modport slave (
    input  INPUT_A,
    input  INPUT_B,
    input  IN_VALID,
    output RES,
    output OUT_VALID
  );
endinterface

// File: rtl/mult_pp_sum.sv
// Sums partial products START..START+COUNT-1 of a*b.
// Ports: a_i, b_i operands; sum_o 2*WIDTH-bit sum.
module mult_pp_sum
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int START = 0,
  parameter int COUNT = WIDTH / 2
) (
  input  logic [WIDTH-1:0]         a_i,
  input  logic [WIDTH-1:0]         b_i,
  output logic [prod_w(WIDTH)-1:0] sum_o
);
  localparam int PW = prod_w(WIDTH);

  logic [PW-1:0] acc;
  logic [PW-1:0] pp;

  always_comb begin
    acc = '0;
    pp  = '0;
    for (int i = 0; i < COUNT; i++) begin
      pp  = {PW{b_i[START+i]}}
          & (PW'(a_i) << (START + i));
      acc = acc + pp;
    end
    sum_o = acc;
  end
endmodule

// File: rtl/pipelined_multiplier.sv
// Two-stage unsigned multiplier, one product per cycle.
// Ports: clk, rst_n (sync, active-low), bus (slave).
module pipelined_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_multiplier_if.slave bus
);
  localparam int PW   = prod_w(WIDTH);
  localparam int HALF = WIDTH / 2;

  logic [PW-1:0] sum_lo_d;
  logic [PW-1:0] sum_hi_d;
  logic [PW-1:0] sum_lo_q;
  logic [PW-1:0] sum_hi_q;
  logic          v1_q;
  logic [PW-1:0] res_d;
  logic [PW-1:0] res_q;
  logic          ov_q;

  mult_pp_sum #(
    .WIDTH (WIDTH),
    .START (0),
    .COUNT (HALF)
  ) u_lo (
    .a_i   (bus.INPUT_A),
    .b_i   (bus.INPUT_B),
    .sum_o (sum_lo_d)
  );

  mult_pp_sum #(
    .WIDTH (WIDTH),
    .START (HALF),
    .COUNT (WIDTH - HALF)
  ) u_hi (
    .a_i   (bus.INPUT_A),
    .b_i   (bus.INPUT_B),
    .sum_o (sum_hi_d)
  );

  assign res_d = sum_lo_q + sum_hi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_lo_q <= '0;
      sum_hi_q <= '0;
      v1_q     <= 1'b0;
      res_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      sum_lo_q <= sum_lo_d;
      sum_hi_q <= sum_hi_d;
      v1_q     <= bus.IN_VALID;
      res_q    <= res_d;
      ov_q     <= v1_q;
    end
  end

  assign bus.RES       = res_q;
  assign bus.OUT_VALID = ov_q;
endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed and random checks for pipelined_multiplier.
// Drives the interface, compares RES/OUT_VALID to constants.
module tb_pipelined_multiplier;
  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  pipelined_multiplier_if #(.WIDTH(8)) bus ();

  pipelined_multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic       v);
    bus.INPUT_A  = a;
    bus.INPUT_B  = b;
    bus.IN_VALID = v;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] res_e,
                     input logic        ov_e);
    total++;
    if (bus.RES !== res_e ||
        bus.OUT_VALID !== ov_e) begin
      $display("FAIL %s: RES=%0d OV=%b want RES=%0d OV=%b",
               nm, bus.RES, bus.OUT_VALID, res_e, ov_e);
    end else begin
      passed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(8'd7, 8'd9, 1'b1);
    step();
    step();
    chk("reset_hold", 16'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("reset_rel1", 16'd0, 1'b0);
    step();
    chk("reset_rel2", 16'd63, 1'b1);
  endtask

  task automatic test_single();
    drive(8'd5, 8'd8, 1'b1);
    step();
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("single_5x8", 16'd40, 1'b1);
    drive(8'd2, 8'd3, 1'b1);
    step();
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("single_2x3", 16'd6, 1'b1);
    drive(8'd4, 8'd8, 1'b1);
    step();
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("single_4x8", 16'd32, 1'b1);
    step();
    chk("single_idle", 16'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive(8'd5, 8'd8, 1'b1);
    step();
    drive(8'd2, 8'd3, 1'b1);
    step();
    chk("b2b_40", 16'd40, 1'b1);
    drive(8'd4, 8'd8, 1'b1);
    step();
    chk("b2b_6", 16'd6, 1'b1);
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("b2b_32", 16'd32, 1'b1);
    step();
  endtask

  task automatic test_extremes();
    drive(8'd255, 8'd255, 1'b1);
    step();
    drive(8'd255, 8'd0, 1'b1);
    step();
    chk("ext_max", 16'd65025, 1'b1);
    drive(8'd0, 8'd255, 1'b1);
    step();
    chk("ext_b0", 16'd0, 1'b1);
    drive(8'd1, 8'd255, 1'b1);
    step();
    chk("ext_a0", 16'd0, 1'b1);
    drive(8'd128, 8'd2, 1'b1);
    step();
    chk("ext_1x255", 16'd255, 1'b1);
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("ext_128x2", 16'd256, 1'b1);
    step();
  endtask

  task automatic test_valid_and_flush();
    drive(8'd3, 8'd3, 1'b1);
    step();
    drive(8'd9, 8'd9, 1'b0);
    step();
    chk("vld_9", 16'd9, 1'b1);
    drive(8'd4, 8'd4, 1'b1);
    step();
    chk("vld_81", 16'd81, 1'b0);
    drive(8'd6, 8'd7, 1'b1);
    step();
    chk("vld_16", 16'd16, 1'b1);
    rst_n = 1'b0;
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("flush_rst", 16'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("flush_rel1", 16'd0, 1'b0);
    step();
    chk("flush_rel2", 16'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] s1;
    logic        v1;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        v;
    int          errs;
    errs  = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    s1 = '0;
    v1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      v = 1'($urandom);
      drive(a, b, v);
      step();
      total++;
      if (bus.RES !== s1 ||
          bus.OUT_VALID !== v1) begin
        if (errs < 10)
          $display("FAIL rand_%0d: RES=%0d OV=%b want RES=%0d OV=%b",
                   i, bus.RES, bus.OUT_VALID, s1, v1);
        errs++;
      end else begin
        passed++;
      end
      s1 = 16'(a) * 16'(b);
      v1 = v;
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    drive(8'd0, 8'd0, 1'b0);
    test_reset();
    test_single();
    test_back_to_back();
    test_extremes();
    test_valid_and_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
